// File: rtl/cdb_arbiter.sv
// Multi-channel Common Data Bus: per-FU result queues with round-robin grant of up to NUM_CDB heads per cycle.
// Optional feature: define CDB_FLUSH_EN to add the flush input that squashes every pending result.
module cdb_arbiter #(
    parameter int NUM_FU  = 5,
    parameter int NUM_CDB = 2,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 5,
    parameter int ADDR_W  = 5,
    parameter int XLEN    = 32,
    localparam int SRC_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_FU-1:0]         fu_valid,
    output logic [NUM_FU-1:0]         fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
    input  logic [NUM_FU*ADDR_W-1:0]  fu_addr,
    input  logic [NUM_FU*XLEN-1:0]    fu_value,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    output logic [NUM_CDB*ADDR_W-1:0] cdb_addr,
    output logic [NUM_CDB*XLEN-1:0]   cdb_value,
    output logic [NUM_CDB*SRC_W-1:0]  cdb_src
`ifdef CDB_FLUSH_EN
    ,
    input  logic                      flush
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TAG_W + ADDR_W + XLEN;

    logic [ENT_W-1:0]   mem [NUM_FU][DEPTH];
    logic [PTR_W-1:0]   wr_ptr [NUM_FU];
    logic [PTR_W-1:0]   rd_ptr [NUM_FU];
    logic [CNT_W-1:0]   count [NUM_FU];
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   rr_next;
    logic [NUM_FU-1:0]  non_empty;
    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  pop;
    logic [ENT_W-1:0]   head [NUM_FU];
    logic [2*NUM_FU-1:0] ne_dbl;
    logic [2*NUM_FU-1:0] gnt_dbl;
    logic [NUM_FU-1:0]  ne_rot;
    logic [NUM_FU-1:0]  gnt_rot;
    logic [NUM_CDB-1:0] gnt_valid;
    logic [SRC_W-1:0]   gnt_src [NUM_CDB];
    logic [ENT_W-1:0]   gnt_ent [NUM_CDB];
    logic               flush_int;

`ifdef CDB_FLUSH_EN
    assign flush_int = flush;
`else
    assign flush_int = 1'b0;
`endif

    // Queue status from registered counts; ready never looks at this cycle's pop
    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            non_empty[f] = (count[f] != '0);
            fu_ready[f]  = (count[f] < CNT_W'(DEPTH));
            push[f]      = fu_valid[f] & fu_ready[f];
            head[f]      = mem[f][rd_ptr[f]];
        end
    end

    // Round-robin scan in rotated space: position k is FU (rr_ptr + k) mod NUM_FU
    always_comb begin
        int  n;
        int  idx;
        logic take;
        ne_dbl    = {non_empty, non_empty} >> rr_ptr;
        ne_rot    = ne_dbl[NUM_FU-1:0];
        gnt_rot   = '0;
        gnt_valid = '0;
        rr_next   = rr_ptr;
        n         = 0;
        idx       = 0;
        take      = 1'b0;
        for (int c = 0; c < NUM_CDB; c++) begin
            gnt_src[c] = '0;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            idx        = int'(rr_ptr) + k;
            idx        = (idx >= NUM_FU) ? (idx - NUM_FU) : idx;
            take       = ne_rot[k] && (n < NUM_CDB);
            gnt_rot[k] = take;
            for (int c = 0; c < NUM_CDB; c++) begin
                gnt_valid[c] = gnt_valid[c] | (take && (c == n));
                gnt_src[c]   = (take && (c == n)) ? SRC_W'(idx) : gnt_src[c];
            end
            rr_next = take ? ((idx == NUM_FU - 1) ? '0 : SRC_W'(idx + 1)) : rr_next;
            n       = n + (take ? 1 : 0);
        end
        gnt_dbl = {{NUM_FU{1'b0}}, gnt_rot} << rr_ptr;
        pop     = gnt_dbl[NUM_FU-1:0] | gnt_dbl[2*NUM_FU-1:NUM_FU];
    end

    // Head entry of the FU granted to each channel
    always_comb begin
        for (int c = 0; c < NUM_CDB; c++) begin
            gnt_ent[c] = '0;
            for (int f = 0; f < NUM_FU; f++) begin
                gnt_ent[c] = (gnt_src[c] == SRC_W'(f)) ? head[f] : gnt_ent[c];
            end
        end
    end

    // Queue storage and pointers, round-robin pointer and registered CDB outputs
    always_ff @(posedge clock) begin
        if (reset || flush_int) begin
            for (int f = 0; f < NUM_FU; f++) begin
                wr_ptr[f] <= '0;
                rd_ptr[f] <= '0;
                count[f]  <= '0;
            end
            rr_ptr    <= '0;
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_addr  <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (push[f]) begin
                    mem[f][wr_ptr[f]] <= {fu_tag[f*TAG_W +: TAG_W],
                                          fu_addr[f*ADDR_W +: ADDR_W],
                                          fu_value[f*XLEN +: XLEN]};
                    wr_ptr[f] <= wr_ptr[f] + PTR_W'(1);
                end
                if (pop[f]) begin
                    rd_ptr[f] <= rd_ptr[f] + PTR_W'(1);
                end
                if (push[f] && !pop[f]) begin
                    count[f] <= count[f] + CNT_W'(1);
                end else if (!push[f] && pop[f]) begin
                    count[f] <= count[f] - CNT_W'(1);
                end
            end
            rr_ptr <= rr_next;
            for (int c = 0; c < NUM_CDB; c++) begin
                cdb_valid[c]                  <= gnt_valid[c];
                cdb_tag[c*TAG_W +: TAG_W]     <= gnt_valid[c] ? gnt_ent[c][ENT_W-1 -: TAG_W] : '0;
                cdb_addr[c*ADDR_W +: ADDR_W]  <= gnt_valid[c] ? gnt_ent[c][ADDR_W+XLEN-1 -: ADDR_W] : '0;
                cdb_value[c*XLEN +: XLEN]     <= gnt_valid[c] ? gnt_ent[c][XLEN-1:0] : '0;
                cdb_src[c*SRC_W +: SRC_W]     <= gnt_valid[c] ? gnt_src[c] : '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, hand-written corner sequences and random traffic
// compared against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int NF = 5;
    localparam int NC = 2;
    localparam int D  = 2;
    localparam int TW = 5;
    localparam int AW = 5;
    localparam int XL = 32;
    localparam int SW = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [NF-1:0]     fu_valid;
    logic [NF-1:0]     fu_ready;
    logic [NF*TW-1:0]  fu_tag;
    logic [NF*AW-1:0]  fu_addr;
    logic [NF*XL-1:0]  fu_value;
    logic [NC-1:0]     cdb_valid;
    logic [NC*TW-1:0]  cdb_tag;
    logic [NC*AW-1:0]  cdb_addr;
    logic [NC*XL-1:0]  cdb_value;
    logic [NC*SW-1:0]  cdb_src;
`ifdef CDB_FLUSH_EN
    logic              flush;
`endif

    always #5 clock = ~clock;

    cdb_arbiter #(.NUM_FU(NF), .NUM_CDB(NC), .DEPTH(D), .TAG_W(TW), .ADDR_W(AW), .XLEN(XL)) dut (
        .clock(clock), .reset(reset),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_addr(fu_addr), .fu_value(fu_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_addr(cdb_addr),
        .cdb_value(cdb_value), .cdb_src(cdb_src)
`ifdef CDB_FLUSH_EN
        , .flush(flush)
`endif
    );

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        logic [XL-1:0] value;
    } ent_t;

    // reference model state
    ent_t          mq [NF][$];
    int            rr_m;
    logic [NC-1:0] exp_valid;
    ent_t          exp_ent [NC];
    int            exp_src [NC];
    logic [31:0]   seen1 [$];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NF-1:0] valid;
        int            tag_b;
        int            addr_b;
        logic [31:0]   val_b;
        logic [NC-1:0] e_valid;
        int            e_src0;
        int            e_src1;
        int            e_tag0;
        int            e_tag1;
        int            e_addr0;
        logic [31:0]   e_val0;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fu(input int f, input logic [TW-1:0] t, input logic [AW-1:0] a, input logic [XL-1:0] v);
        fu_tag[f*TW +: TW]   = t;
        fu_addr[f*AW +: AW]  = a;
        fu_value[f*XL +: XL] = v;
    endtask

    // Advance the model by one edge from the rules: grants on pre-edge heads, then pushes.
    task automatic model_step();
        int            n;
        int            last;
        logic [NF-1:0] pre_rdy;
        logic [NF-1:0] popf;
        logic          fl;
        ent_t          e;
        fl = 1'b0;
`ifdef CDB_FLUSH_EN
        fl = flush;
`endif
        if (reset || fl) begin
            for (int f = 0; f < NF; f++) mq[f].delete();
            rr_m      = 0;
            exp_valid = '0;
            return;
        end
        for (int f = 0; f < NF; f++) pre_rdy[f] = (mq[f].size() < D);
        n = 0; last = 0; exp_valid = '0; popf = '0;
        for (int k = 0; k < NF; k++) begin
            int f;
            f = (rr_m + k) % NF;
            if (mq[f].size() > 0 && n < NC) begin
                exp_ent[n]   = mq[f][0];
                exp_src[n]   = f;
                exp_valid[n] = 1'b1;
                popf[f]      = 1'b1;
                last         = f;
                n++;
            end
        end
        if (n > 0) rr_m = (last + 1) % NF;
        for (int f = 0; f < NF; f++) if (popf[f]) void'(mq[f].pop_front());
        for (int f = 0; f < NF; f++) begin
            if (fu_valid[f] && pre_rdy[f]) begin
                e.tag   = fu_tag[f*TW +: TW];
                e.addr  = fu_addr[f*AW +: AW];
                e.value = fu_value[f*XL +: XL];
                mq[f].push_back(e);
            end
        end
    endtask

    task automatic tick();
        logic [NF-1:0] exp_rdy;
        model_step();
        @(posedge clock);
        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
        for (int c = 0; c < NC; c++) begin
            if (exp_valid[c]) begin
                check($sformatf("tag%0d", c),   64'(cdb_tag[c*TW +: TW]),   64'(exp_ent[c].tag));
                check($sformatf("addr%0d", c),  64'(cdb_addr[c*AW +: AW]),  64'(exp_ent[c].addr));
                check($sformatf("value%0d", c), 64'(cdb_value[c*XL +: XL]), 64'(exp_ent[c].value));
                check($sformatf("src%0d", c),   64'(cdb_src[c*SW +: SW]),   64'(exp_src[c]));
            end
            if (cdb_valid[c] && cdb_src[c*SW +: SW] == 3'd1) seen1.push_back(cdb_value[c*XL +: XL]);
        end
        for (int f = 0; f < NF; f++) exp_rdy[f] = (mq[f].size() < D);
        check("fu_ready", 64'(fu_ready), 64'(exp_rdy));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp1 [$];
        logic [31:0] r;
        int          n1;
        int          g;
        logic        pre;

        rr_m = 0; exp_valid = '0;
        reset = 1'b1; fu_valid = '1; fu_tag = '0; fu_addr = '0; fu_value = '0;
`ifdef CDB_FLUSH_EN
        flush = 1'b0;
`endif
        // reset held two cycles with every FU presenting a result
        tick();
        tick();
        check("rst_tag",   64'(cdb_tag),   64'd0);
        check("rst_addr",  64'(cdb_addr),  64'd0);
        check("rst_value", 64'(cdb_value), 64'd0);
        check("rst_src",   64'(cdb_src),   64'd0);
        reset = 1'b0; fu_valid = '0;
        tick();
        check("rst_ready", 64'(fu_ready),  64'(5'b11111));
        check("rst_valid", 64'(cdb_valid), 64'(2'b00));

        // round robin from rr_ptr=0, then single FU2 result
        tbl[0] = '{5'b11111, 0, 10, 32'd100,        2'b00, 0, 0, 0, 0, 0,  32'd0};
        tbl[1] = '{5'b00000, 0, 0,  32'd0,          2'b11, 0, 1, 0, 1, 10, 32'd100};
        tbl[2] = '{5'b00000, 0, 0,  32'd0,          2'b11, 2, 3, 2, 3, 12, 32'd102};
        tbl[3] = '{5'b00000, 0, 0,  32'd0,          2'b01, 4, 0, 4, 0, 14, 32'd104};
        tbl[4] = '{5'b00100, 5, 1,  32'hDEADBEED,   2'b00, 0, 0, 0, 0, 0,  32'd0};
        tbl[5] = '{5'b00000, 0, 0,  32'd0,          2'b01, 2, 0, 7, 0, 3,  32'hDEADBEEF};
        tbl[6] = '{5'b00000, 0, 0,  32'd0,          2'b00, 0, 0, 0, 0, 0,  32'd0};
        for (int i = 0; i < 7; i++) begin
            fu_valid = tbl[i].valid;
            for (int f = 0; f < NF; f++)
                set_fu(f, TW'(tbl[i].tag_b + f), AW'(tbl[i].addr_b + f), tbl[i].val_b + 32'(f));
            tick();
            check("tbl_valid", 64'(cdb_valid), 64'(tbl[i].e_valid));
            check("tbl_ready", 64'(fu_ready),  64'(5'b11111));
            if (tbl[i].e_valid[0]) begin
                check("tbl_src0",  64'(cdb_src[SW-1:0]),  64'(tbl[i].e_src0));
                check("tbl_tag0",  64'(cdb_tag[TW-1:0]),  64'(tbl[i].e_tag0));
                check("tbl_addr0", 64'(cdb_addr[AW-1:0]), 64'(tbl[i].e_addr0));
                check("tbl_val0",  64'(cdb_value[XL-1:0]), 64'(tbl[i].e_val0));
            end
            if (tbl[i].e_valid[1]) begin
                check("tbl_src1", 64'(cdb_src[2*SW-1:SW]), 64'(tbl[i].e_src1));
                check("tbl_tag1", 64'(cdb_tag[2*TW-1:TW]), 64'(tbl[i].e_tag1));
            end
        end

        // back-pressure: FU1 offers three results while FU0 and FU4 keep their queues busy
        seen1.delete();
        n1 = 0; g = 0;
        while (n1 < 3 && g < 20) begin
            fu_valid = 5'b10011;
            set_fu(0, 5'd1, 5'd1, 32'h4000_0000 + 32'(g));
            set_fu(4, 5'd2, 5'd2, 32'h4400_0000 + 32'(g));
            set_fu(1, TW'(20 + n1), 5'd9, 32'h1111_0000 + 32'(n1));
            pre = (mq[1].size() < D);
            if (pre) exp1.push_back(32'h1111_0000 + 32'(n1));
            tick();
            if (pre) n1++;
            if (g == 1) check("bp_full", 64'(fu_ready[1]), 64'd0);
            g++;
        end
        check("bp_accepted", 64'(n1), 64'd3);
        fu_valid = '0;
        repeat (6) tick();
        check("bp_order_cnt", 64'(seen1.size()), 64'(exp1.size()));
        for (int i = 0; i < exp1.size() && i < seen1.size(); i++)
            check("bp_order", 64'(seen1[i]), 64'(exp1[i]));

        // FU3 streams one result per cycle with no competitors
        for (int k = 0; k < 8; k++) begin
            fu_valid = 5'b01000;
            set_fu(3, TW'(k), 5'd4, 32'h5000_0000 + 32'(k));
            tick();
            check("stream_ready", 64'(fu_ready[3]), 64'd1);
            if (k > 0) begin
                check("stream_valid", 64'(cdb_valid), 64'(2'b01));
                check("stream_value", 64'(cdb_value[XL-1:0]), 64'(32'h5000_0000 + 32'(k - 1)));
            end
        end
        fu_valid = '0;
        tick();
        check("stream_last", 64'(cdb_value[XL-1:0]), 64'(32'h5000_0007));

`ifdef CDB_FLUSH_EN
        // flush with four queued results
        fu_valid = 5'b01111;
        for (int f = 0; f < NF; f++) set_fu(f, TW'(f), AW'(f), 32'h6000_0000 + 32'(f));
        tick();
        flush = 1'b1; fu_valid = 5'b11111;
        tick();
        check("flush_valid", 64'(cdb_valid), 64'd0);
        check("flush_ready", 64'(fu_ready),  64'(5'b11111));
        flush = 1'b0; fu_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush_stale", 64'(cdb_valid), 64'd0);
        end
`endif

        // random traffic with occasional mid-operation reset
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            fu_valid = r[NF-1:0];
            for (int f = 0; f < NF; f++) begin
                r = $urandom;
                set_fu(f, r[TW-1:0], r[TW+AW-1:TW], $urandom);
            end
            reset = ($urandom_range(0, 63) == 0);
`ifdef CDB_FLUSH_EN
            flush = ($urandom_range(0, 47) == 0);
`endif
            tick();
        end
        reset = 1'b0; fu_valid = '0;
`ifdef CDB_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
